// File: rtl/sa_seq_pkg.sv
// rtl/sa_seq_pkg.sv - shared types and constants for the systolic array sequencer
package sa_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Stages after the PE input register: multiply, accumulate, output.
   localparam int PE_PIPE_LAT = 3;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   // Wide enough for K+N-2 at K = 2^KW-1 without wrapping.
   function automatic int feed_cnt_width(input int kw, input int n);
      return kw + $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sa_lane_skew.sv
// rtl/sa_lane_skew.sv - skewed enable and operand index for one feed lane
module sa_lane_skew #(
   parameter int KW   = 8,
   parameter int FCW  = 10,
   parameter int LANE = 0
) (
   input  logic [FCW-1:0] feed_cnt,
   input  logic [KW-1:0]  k,
   output logic           en,
   output logic [KW-1:0]  idx
);

   logic [FCW-1:0] lo;
   logic [FCW-1:0] hi;

   assign lo  = FCW'(LANE);
   assign hi  = lo + FCW'(k);
   assign en  = (feed_cnt >= lo) && (feed_cnt < hi);
   assign idx = en ? KW'(feed_cnt - lo) : '0;

endmodule

// File: rtl/systolic_array_sequencer.sv
// rtl/systolic_array_sequencer.sv - job sequencer for an N x N PE grid
// Optional perf counters (job_count, busy_cycles) under SA_SEQ_PERF_EN.
module systolic_array_sequencer
   import sa_seq_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   output logic            busy,
   output logic            start_err,
   output logic            pe_rst_n,
   output logic [N-1:0]    lane_en,
   output logic [N*KW-1:0] lane_idx,
   output logic            result_valid,
   input  logic            result_ack
`ifdef SA_SEQ_PERF_EN
   ,
   output logic [15:0]     job_count,
   output logic [31:0]     busy_cycles
`endif
);

   localparam int FCW = feed_cnt_width(KW, N);
   localparam int DCW = $clog2(N + 3);

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [FCW-1:0]  feed_cnt_q, feed_cnt_d;
   logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
   logic [FCW-1:0]  feed_last;
   logic [DCW-1:0]  drain_last;
   logic [N-1:0]    en_d;
   logic [N*KW-1:0] idx_d;

   logic            busy_d, start_err_d, pe_rst_n_d, result_valid_d;
   logic [N-1:0]    lane_en_d;
   logic [N*KW-1:0] lane_idx_d;

   assign feed_last  = FCW'(k_q) + FCW'(N) - FCW'(2);
   // N-1 hops to the far corner, then the PE pipeline stages.
   assign drain_last = DCW'(N - 1 + PE_PIPE_LAT - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         feed_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         busy         <= 1'b0;
         start_err    <= 1'b0;
         pe_rst_n     <= 1'b0;
         lane_en      <= '0;
         lane_idx     <= '0;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         feed_cnt_q   <= feed_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         busy         <= busy_d;
         start_err    <= start_err_d;
         pe_rst_n     <= pe_rst_n_d;
         lane_en      <= lane_en_d;
         lane_idx     <= lane_idx_d;
         result_valid <= result_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      feed_cnt_d  = feed_cnt_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && (k_len != '0)) begin
               state_d = S_CLEAR;
               k_d     = k_len;
            end
         end
         S_CLEAR: begin
            state_d    = S_FEED;
            feed_cnt_d = '0;
         end
         S_FEED: begin
            if (feed_cnt_q == feed_last) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end else begin
               feed_cnt_d = feed_cnt_q + FCW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == drain_last) state_d = S_DONE;
            else drain_cnt_d = drain_cnt_q + DCW'(1);
         end
         S_DONE: begin
            if (result_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      sa_lane_skew #(
         .KW   (KW),
         .FCW  (FCW),
         .LANE (i)
      ) u_skew (
         .feed_cnt (feed_cnt_d),
         .k        (k_q),
         .en       (en_d[i]),
         .idx      (idx_d[i*KW +: KW])
      );
   end

   // Outputs are decoded from the next state so they are registered yet aligned to it.
   always_comb begin
      busy_d         = (state_d != S_IDLE);
      pe_rst_n_d     = (state_d != S_CLEAR);
      result_valid_d = (state_d == S_DONE);
      start_err_d    = (state_q == S_IDLE) && start && (k_len == '0);
      lane_en_d      = '0;
      lane_idx_d     = '0;
      if (state_d == S_FEED) begin
         lane_en_d  = en_d;
         lane_idx_d = idx_d;
      end
   end

`ifdef SA_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_count   <= '0;
         busy_cycles <= '0;
      end else begin
         if ((state_q == S_DONE) && result_ack && (job_count != 16'hFFFF))
            job_count <= job_count + 16'd1;
         if (busy && (busy_cycles != 32'hFFFF_FFFF))
            busy_cycles <= busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb/tb_systolic_array_sequencer.sv - self-checking bench for systolic_array_sequencer
module tb_systolic_array_sequencer;

   localparam int N  = 4;
   localparam int KW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            start_err;
   logic            pe_rst_n;
   logic [N-1:0]    lane_en;
   logic [N*KW-1:0] lane_idx;
   logic            result_valid;
   logic            result_ack;
`ifdef SA_SEQ_PERF_EN
   logic [15:0]     job_count;
   logic [31:0]     busy_cycles;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int model_jobs  = 0;
   int model_busy  = 0;

   always #5 clk = ~clk;

   systolic_array_sequencer #(.N(N), .KW(KW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .k_len        (k_len),
      .busy         (busy),
      .start_err    (start_err),
      .pe_rst_n     (pe_rst_n),
      .lane_en      (lane_en),
      .lane_idx     (lane_idx),
      .result_valid (result_valid),
      .result_ack   (result_ack)
`ifdef SA_SEQ_PERF_EN
      ,
      .job_count    (job_count),
      .busy_cycles  (busy_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs e edges after the edge that sampled START, from the job timeline:
   // edge 0 -> CLEAR, edges 1..K+N-1 -> FEED (cnt=e-1), then DRAIN, DONE at K+2N+2.
   task automatic check_cycle(input int e, input int k);
      int last;
      int c;
      logic [N-1:0]    een;
      logic [N*KW-1:0] eidx;
      last = k + 2*N + 2;
      een  = '0;
      eidx = '0;
      if (e >= 1 && e <= k + N - 1) begin
         c = e - 1;
         for (int i = 0; i < N; i++) begin
            if (c >= i && c < i + k) begin
               een[i]            = 1'b1;
               eidx[i*KW +: KW]  = KW'(c - i);
            end
         end
      end
      chk("busy",         32'(busy),         32'(1));
      chk("pe_rst_n",     32'(pe_rst_n),     32'(e != 0));
      chk("start_err",    32'(start_err),    32'(0));
      chk("result_valid", 32'(result_valid), 32'(e == last));
      chk("lane_en",      32'(lane_en),      32'(een));
      chk("lane_idx",     32'(lane_idx),     32'(eidx));
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_job(input int k, input int hold, input bit start_on_ack);
      int last;
      last  = k + 2*N + 2;
      start = 1'b1;
      k_len = KW'(k);
      for (int e = 0; e <= last; e++) begin
         @(negedge clk);
         check_cycle(e, k);
         if (e < last) begin
            start      = 1'($urandom_range(0, 1));
            result_ack = 1'($urandom_range(0, 1));
         end else begin
            start      = 1'b0;
            result_ack = 1'b0;
         end
      end
      for (int h = 0; h < hold; h++) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_valid", 32'(result_valid), 32'(1));
         chk("hold_lane",  32'(lane_en),      32'(0));
      end
      result_ack = 1'b1;
      start      = start_on_ack;
      @(negedge clk);
      result_ack = 1'b0;
      start      = 1'b0;
      chk("ack_valid", 32'(result_valid), 32'(0));
      chk("ack_busy",  32'(busy),         32'(0));
      @(negedge clk);
      chk("post_ack_busy", 32'(busy),     32'(0));
      chk("post_ack_pe",   32'(pe_rst_n), 32'(1));
      model_jobs++;
      model_busy += k + 2*N + 3 + hold;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      k_len      = '0;
      result_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pe_rst_n",  32'(pe_rst_n),     32'(0));
      chk("rst_busy",      32'(busy),         32'(0));
      chk("rst_start_err", 32'(start_err),    32'(0));
      chk("rst_lane_en",   32'(lane_en),      32'(0));
      chk("rst_lane_idx",  32'(lane_idx),     32'(0));
      chk("rst_valid",     32'(result_valid), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_pe_rst_n", 32'(pe_rst_n), 32'(1));

      run_job(4, 0, 1'b0);
      run_job(1, 5, 1'b0);

      start = 1'b1;
      k_len = '0;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 32'(start_err), 32'(1));
      chk("err_busy",  32'(busy),      32'(0));
      chk("err_pe",    32'(pe_rst_n),  32'(1));
      @(negedge clk);
      chk("err_clear", 32'(start_err), 32'(0));
      chk("err_idle",  32'(busy),      32'(0));

      run_job(3, 0, 1'b1);
      for (int j = 0; j < 6; j++)
         run_job($urandom_range(1, 24), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      run_job(255, 1, 1'b0);

      // Reset while FEED_CNT==3.
      start = 1'b1;
      k_len = KW'(5);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_lane_en", 32'(lane_en), 32'(4'hF));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lane", 32'(lane_en),  32'(0));
      chk("mid_rst_pe",   32'(pe_rst_n), 32'(0));
      chk("mid_rst_busy", 32'(busy),     32'(0));
      model_jobs = 0;
      model_busy = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(2, 0, 1'b0);
      run_job(7, 2, 1'b0);

`ifdef SA_SEQ_PERF_EN
      chk("job_count",   32'(job_count), 32'(model_jobs));
      chk("busy_cycles", busy_cycles,    32'(model_busy));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
